// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// Carries operands, mode and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop.
// Processes one bit per clock, LSB first, with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] op_a_q, op_b_q, res_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q;
    logic             s_bit, c_bit, last;

    assign s_bit = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign c_bit = (op_a_q[0] & op_b_q[0]) |
                   (op_a_q[0] & carry_q) |
                   (op_b_q[0] & carry_q);
    assign last  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Subtract is a + ~b + 1, so the mode folds into operand and carry load.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    res_q   <= {s_bit, res_q[WIDTH-1:1]};
                    carry_q <= c_bit;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        sum_q  <= {s_bit, res_q[WIDTH-1:1]};
                        cout_q <= c_bit;
                        // carry_q here is the carry into the MSB
                        ovf_q  <= carry_q ^ c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder at WIDTH 8 and 3.
// Results are checked against plain integer arithmetic.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) b8 ();
    serial_adder_if #(.WIDTH(3)) b3 ();

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    logic        sel = 1'b0;
    logic        start_d = 1'b0;
    logic [31:0] a_d = '0;
    logic [31:0] b_d = '0;
    logic        cin_d = 1'b0;
    logic        sub_d = 1'b0;

    assign b8.start = start_d & ~sel;
    assign b8.a     = a_d[7:0];
    assign b8.b     = b_d[7:0];
    assign b8.cin   = cin_d;
    assign b8.sub   = sub_d;
    assign b3.start = start_d & sel;
    assign b3.a     = a_d[2:0];
    assign b3.b     = b_d[2:0];
    assign b3.cin   = cin_d;
    assign b3.sub   = sub_d;

    logic        busy_s, done_s, cout_s, ovf_s;
    logic [31:0] sum_s;
    assign busy_s = sel ? b3.busy : b8.busy;
    assign done_s = sel ? b3.done : b8.done;
    assign sum_s  = sel ? 32'(b3.sum) : 32'(b8.sum);
    assign cout_s = sel ? b3.cout : b8.cout;
    assign ovf_s  = sel ? b3.ovf : b8.ovf;

    int checks = 0;
    int errors = 0;

    longint prev_sum [2];
    bit     prev_cout[2];
    bit     prev_ovf [2];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input longint a, input longint b,
                                  input bit cin, input bit sub,
                                  output longint sum, output bit cout,
                                  output bit ovf);
        longint mask, bb, t;
        bit sa, sb, ss;
        mask = (longint'(1) << w) - 1;
        a    = a & mask;
        bb   = sub ? (~b & mask) : (b & mask);
        t    = a + bb + longint'(sub ? 1'b1 : cin);
        sum  = t & mask;
        cout = t[w];
        sa   = a[w-1];
        sb   = bb[w-1];
        ss   = sum[w-1];
        ovf  = (sa == sb) && (ss != sa);
    endfunction

    task automatic op(input int w, input longint a, input longint b,
                      input bit cin, input bit sub, input bit disturb);
        longint esum;
        bit ecout, eovf, stable;
        int cyc, busy_n, k;
        k = (w == 3) ? 1 : 0;
        model(w, a, b, cin, sub, esum, ecout, eovf);
        @(negedge clk);
        sel     = (w == 3);
        start_d = 1'b1;
        a_d     = 32'(a);
        b_d     = 32'(b);
        cin_d   = cin;
        sub_d   = sub;
        @(negedge clk);
        start_d = 1'b0;
        cyc = 1;
        busy_n = 0;
        stable = 1'b1;
        while (!done_s && cyc <= w + 4) begin
            if (busy_s) busy_n++;
            if (sum_s != 32'(prev_sum[k]) || cout_s != prev_cout[k] ||
                ovf_s != prev_ovf[k])
                stable = 1'b0;
            if (disturb && cyc == 2) begin
                start_d = 1'b1;
                a_d     = $urandom;
                b_d     = $urandom;
                cin_d   = ~cin;
                sub_d   = ~sub;
            end
            if (disturb && cyc == 3) start_d = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, w + 1);
        chk("busy_len", busy_n, w);
        chk("stable", stable, 1);
        chk("sum", sum_s, esum);
        chk("cout", cout_s, ecout);
        chk("ovf", ovf_s, eovf);
        @(negedge clk);
        chk("done_once", done_s, 0);
        chk("idle_busy", busy_s, 0);
        prev_sum[k]  = esum;
        prev_cout[k] = ecout;
        prev_ovf[k]  = eovf;
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 2; i++) begin
            prev_sum[i]  = 0;
            prev_cout[i] = 0;
            prev_ovf[i]  = 0;
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy8", b8.busy, 0);
        chk("rst_done8", b8.done, 0);
        chk("rst_sum8", b8.sum, 0);
        chk("rst_cout8", b8.cout, 0);
        chk("rst_ovf8", b8.ovf, 0);
        chk("rst_sum3", b3.sum, 0);

        op(8, 'h3C, 'h05, 0, 0, 0);
        op(8, 'hFF, 'h01, 0, 0, 0);
        op(8, 'h7F, 'h01, 0, 0, 0);
        op(8, 'h7F, 'h00, 1, 0, 0);
        op(8, 'h10, 'h20, 1, 1, 0);
        op(8, 'h80, 'h01, 0, 1, 0);
        chk("tp_sub_sum", b8.sum, 'h7F);
        op(8, 'h12, 'h34, 0, 0, 1);

        for (int i = 0; i < 30; i++)
            op(8, $urandom, $urandom, 1'($urandom), 1'($urandom),
               1'($urandom));

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++)
                    op(3, a, b, 1'(c), 0, 0);
                op(3, a, b, 0, 1, 0);
            end

        @(negedge clk);
        sel     = 1'b0;
        start_d = 1'b1;
        a_d     = 'hAA;
        b_d     = 'h55;
        cin_d   = 1'b0;
        sub_d   = 1'b0;
        @(negedge clk);
        start_d = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", b8.busy, 0);
        chk("abort_done", b8.done, 0);
        chk("abort_sum", b8.sum, 0);
        chk("abort_cout", b8.cout, 0);
        chk("abort_ovf", b8.ovf, 0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (b8.done) dones++;
        end
        chk("abort_nodone", dones, 0);
        for (int i = 0; i < 2; i++) begin
            prev_sum[i]  = 0;
            prev_cout[i] = 0;
            prev_ovf[i]  = 0;
        end
        op(8, 'hAA, 'h55, 0, 0, 0);

        @(negedge clk);
        sel     = 1'b0;
        rst     = 1'b1;
        start_d = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_d = 1'b0;
        chk("rst_start_busy", b8.busy, 0);
        @(negedge clk);
        chk("rst_start_idle", b8.busy, 0);
        chk("rst_start_sum", b8.sum, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
